// File: rtl/booth_multiplier_r4.sv
// rtl/booth_multiplier_r4.sv - sequential radix-4 Booth multiplier, signed/unsigned, start/busy/done handshake
// Operands are widened by two bits so one digit count serves both signed and full-range unsigned inputs.
`timescale 1ns/1ps

module booth_multiplier_r4 #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int NITER = WIDTH / 2 + 1;
   localparam int XW    = WIDTH + 2;
   localparam int AW    = XW + 1;
   localparam int CW    = $clog2(NITER + 1);

   generate
      if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_width_check
         $error("booth_multiplier_r4: WIDTH must be even and >= 4");
      end
   endgenerate

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic              accept;
   logic              finish;
   logic              last_digit;

   logic [XW-1:0]     m_q;
   logic [XW-1:0]     q_q;
   logic [AW-1:0]     a_q;
   logic              q_m1_q;
   logic [CW-1:0]     count_q;

   logic [XW-1:0]     m_ext;
   logic [XW-1:0]     q_ext;
   logic [AW-1:0]     m_sx;
   logic [AW-1:0]     m_dbl;
   logic [AW-1:0]     addend;
   logic [AW-1:0]     a_sum;
   logic [AW-1:0]     a_next;
   logic [XW-1:0]     q_next;
   logic              q_m1_next;
   logic [2*WIDTH-1:0] product_next;

   // Sign bit is replicated only in signed mode; unsigned operands get two zero bits.
   assign m_ext = {{2{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
   assign q_ext = {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier};

   assign m_sx  = {m_q[XW-1], m_q};
   assign m_dbl = {m_q, 1'b0};

   always_comb begin
      addend = '0;
      case ({q_q[1:0], q_m1_q})
         3'b001, 3'b010: addend = m_sx;
         3'b011:         addend = m_dbl;
         3'b100:         addend = -m_dbl;
         3'b101, 3'b110: addend = -m_sx;
         default:        addend = '0;
      endcase
   end

   assign a_sum = a_q + addend;

   // Arithmetic shift of {A, Q, q_m1} by two places.
   assign {a_next, q_next, q_m1_next} = {a_sum[AW-1], a_sum[AW-1], a_sum, q_q[XW-1:1]};

   assign product_next = {a_next[WIDTH-3:0], q_next};
   assign last_digit   = (count_q == CW'(NITER - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (last_digit) begin
               finish  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q     <= '0;
         q_q     <= '0;
         a_q     <= '0;
         q_m1_q  <= 1'b0;
         count_q <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         if (accept) begin
            m_q     <= m_ext;
            q_q     <= q_ext;
            a_q     <= '0;
            q_m1_q  <= 1'b0;
            count_q <= '0;
         end else if (state_q == RUN) begin
            a_q     <= a_next;
            q_q     <= q_next;
            q_m1_q  <= q_m1_next;
            count_q <= count_q + CW'(1);
         end
         busy <= (state_d == RUN);
         done <= finish;
         if (finish) begin
            product <= product_next;
         end
      end
   end

endmodule

// File: tb/tb_booth_multiplier_r4.sv
// tb/tb_booth_multiplier_r4.sv - self-checking bench for booth_multiplier_r4 at WIDTH 4, 8 and 16
`timescale 1ns/1ps

module tb_booth_multiplier_r4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   logic        st4 = 0, sm4 = 0, busy4, done4;
   logic [3:0]  m4 = 0, q4 = 0;
   logic [7:0]  p4;
   logic        st8 = 0, sm8 = 0, busy8, done8;
   logic [7:0]  m8 = 0, q8 = 0;
   logic [15:0] p8;
   logic        st16 = 0, sm16 = 0, busy16, done16;
   logic [15:0] m16 = 0, q16 = 0;
   logic [31:0] p16;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   booth_multiplier_r4 #(.WIDTH(4)) u4 (
      .clk(clk), .reset_n(reset_n), .start(st4), .signed_mode(sm4),
      .multiplicand(m4), .multiplier(q4), .busy(busy4), .done(done4), .product(p4));
   booth_multiplier_r4 #(.WIDTH(8)) u8 (
      .clk(clk), .reset_n(reset_n), .start(st8), .signed_mode(sm8),
      .multiplicand(m8), .multiplier(q8), .busy(busy8), .done(done8), .product(p8));
   booth_multiplier_r4 #(.WIDTH(16)) u16 (
      .clk(clk), .reset_n(reset_n), .start(st16), .signed_mode(sm16),
      .multiplicand(m16), .multiplier(q16), .busy(busy16), .done(done16), .product(p16));

   function automatic logic [31:0] ref_mul(int w, bit s, logic [15:0] a, logic [15:0] b);
      longint av, bv, p, mask;
      mask = (longint'(1) << w) - 1;
      av = longint'(a) & mask;
      bv = longint'(b) & mask;
      if (s && a[w-1]) av = av - (longint'(1) << w);
      if (s && b[w-1]) bv = bv - (longint'(1) << w);
      p = (av * bv) & ((longint'(1) << (2 * w)) - 1);
      return 32'(p);
   endfunction

   function automatic logic [15:0] pick(int w);
      int sel;
      logic [15:0] mask;
      sel = $urandom_range(0, 7);
      mask = 16'((32'd1 << w) - 1);
      case (sel)
         0: return 16'd0;
         1: return 16'd1;
         2: return mask;
         3: return 16'(32'd1 << (w - 1));
         4: return mask >> 1;
         default: return 16'($urandom) & mask;
      endcase
   endfunction

   task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p, output int lat);
      @(negedge clk);
      sm8 = s; m8 = a; q8 = b; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      p = p8;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'h0) begin
         fails++;
         $display("FAIL reset_w8: busy=%b done=%b product=%h required 0 0 0000", busy8, done8, p8);
      end
      tests++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || p4 !== 8'h0 || busy16 !== 1'b0 || done16 !== 1'b0 || p16 !== 32'h0) begin
         fails++;
         $display("FAIL reset_w4_w16: busy4=%b done4=%b p4=%h busy16=%b done16=%b p16=%h required all 0",
                  busy4, done4, p4, busy16, done16, p16);
      end
      reset_n = 1'b1;
      @(negedge clk);
      tests++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'h0) begin
         fails++;
         $display("FAIL post_reset_idle: busy=%b done=%b product=%h required 0 0 0000", busy8, done8, p8);
      end
   endtask

   task automatic test_corners();
      logic [15:0] p;
      int lat;
      run8(1'b1, 8'h80, 8'h80, p, lat);
      tests++;
      if (p !== 16'h4000) begin
         fails++;
         $display("FAIL min_x_min_signed: product=%h required 4000", p);
      end
      tests++;
      if (lat !== 5) begin
         fails++;
         $display("FAIL latency: cycles=%0d required 5", lat);
      end
      run8(1'b0, 8'hFF, 8'hFF, p, lat);
      tests++;
      if (p !== 16'hFE01) begin
         fails++;
         $display("FAIL max_x_max_unsigned: product=%h required fe01", p);
      end
      run8(1'b1, 8'hFF, 8'hFF, p, lat);
      tests++;
      if (p !== 16'h0001) begin
         fails++;
         $display("FAIL m1_x_m1_signed: product=%h required 0001", p);
      end
   endtask

   task automatic test_back_to_back();
      int n, t1, t2;
      logic [15:0] r1, r2;
      n = 0; t1 = 0; t2 = 0; r1 = 0; r2 = 0;
      @(negedge clk);
      sm8 = 1'b1; m8 = 8'h7F; q8 = 8'h80; st8 = 1'b1;
      @(negedge clk);
      m8 = 8'hFD; q8 = 8'h05;
      for (int c = 1; c <= 30 && n < 2; c++) begin
         @(negedge clk);
         if (done8) begin
            n++;
            if (n == 1) begin
               t1 = c; r1 = p8;
            end else begin
               t2 = c; r2 = p8; st8 = 1'b0;
            end
         end else if (n == 1) begin
            tests++;
            if (p8 !== 16'hC080) begin
               fails++;
               $display("FAIL b2b_hold: product=%h required c080", p8);
            end
         end
      end
      st8 = 1'b0;
      tests++;
      if (n != 2) begin
         fails++;
         $display("FAIL b2b_pulses: done pulses=%0d required 2", n);
      end
      tests++;
      if (r1 !== 16'hC080 || r2 !== 16'hFFF1) begin
         fails++;
         $display("FAIL b2b_products: first=%h second=%h required c080 fff1", r1, r2);
      end
      tests++;
      if (t1 != 5 || t2 - t1 != 6) begin
         fails++;
         $display("FAIL b2b_timing: first at %0d spacing %0d required 5 and 6", t1, t2 - t1);
      end
      @(negedge clk);
      tests++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
         fails++;
         $display("FAIL b2b_tail: done=%b busy=%b required 0 0", done8, busy8);
      end
   endtask

   task automatic test_ignore_start();
      int pulses, lat;
      logic [15:0] res, e16;
      logic [31:0] e;
      pulses = 0; lat = 0; res = 0;
      e = ref_mul(8, 1'b1, 16'h0035, 16'h00C7);
      e16 = e[15:0];
      @(negedge clk);
      sm8 = 1'b1; m8 = 8'h35; q8 = 8'hC7; st8 = 1'b1;
      @(negedge clk);
      sm8 = 1'b0; m8 = 8'h12; q8 = 8'h34;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (c == 3) st8 = 1'b0;
         if (done8) begin
            pulses++;
            if (pulses == 1) begin
               lat = c; res = p8;
            end
         end
      end
      tests++;
      if (pulses != 1 || lat != 5) begin
         fails++;
         $display("FAIL ignore_start_pulses: pulses=%0d at %0d required 1 at 5", pulses, lat);
      end
      tests++;
      if (res !== e16) begin
         fails++;
         $display("FAIL ignore_start_product: product=%h required %h", res, e16);
      end
   endtask

   task automatic test_reset_mid_op();
      int seen;
      int lat;
      logic [15:0] p;
      seen = 0;
      @(negedge clk);
      sm8 = 1'b0; m8 = 8'h5A; q8 = 8'h3C; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      tests++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'h0) begin
         fails++;
         $display("FAIL reset_mid_op: busy=%b done=%b product=%h required 0 0 0000", busy8, done8, p8);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done8 || busy8) seen++;
      end
      tests++;
      if (seen != 0) begin
         fails++;
         $display("FAIL reset_no_done: active cycles after abort=%0d required 0", seen);
      end
      run8(1'b0, 8'hC8, 8'h0B, p, lat);
      tests++;
      if (p !== 16'h0898 || lat != 5) begin
         fails++;
         $display("FAIL after_reset_op: product=%h latency=%0d required 0898 and 5", p, lat);
      end
   endtask

   task automatic test_random();
      logic [15:0] a4, b4, a8, b8, a16, b16;
      logic [31:0] e4, e8, e16;
      logic [7:0]  r4;
      logic [15:0] r8;
      logic [31:0] r16;
      bit s4, s8, s16, g4, g8, g16;
      for (int i = 0; i < 3400; i++) begin
         @(negedge clk);
         a4 = pick(4); b4 = pick(4); s4 = 1'($urandom);
         a8 = pick(8); b8 = pick(8); s8 = 1'($urandom);
         a16 = pick(16); b16 = pick(16); s16 = 1'($urandom);
         sm4 = s4; m4 = a4[3:0]; q4 = b4[3:0]; st4 = 1'b1;
         sm8 = s8; m8 = a8[7:0]; q8 = b8[7:0]; st8 = 1'b1;
         sm16 = s16; m16 = a16; q16 = b16; st16 = 1'b1;
         e4 = ref_mul(4, s4, a4, b4);
         e8 = ref_mul(8, s8, a8, b8);
         e16 = ref_mul(16, s16, a16, b16);
         g4 = 0; g8 = 0; g16 = 0; r4 = 0; r8 = 0; r16 = 0;
         @(negedge clk);
         st4 = 1'b0; st8 = 1'b0; st16 = 1'b0;
         for (int c = 0; c < 20 && !(g4 && g8 && g16); c++) begin
            @(negedge clk);
            if (done4 && !g4) begin g4 = 1; r4 = p4; end
            if (done8 && !g8) begin g8 = 1; r8 = p8; end
            if (done16 && !g16) begin g16 = 1; r16 = p16; end
         end
         tests++;
         if (!g4 || r4 !== e4[7:0]) begin
            fails++;
            $display("FAIL rand_w4: s=%b %h*%h product=%h done=%b required %h", s4, a4[3:0], b4[3:0], r4, g4, e4[7:0]);
         end
         tests++;
         if (!g8 || r8 !== e8[15:0]) begin
            fails++;
            $display("FAIL rand_w8: s=%b %h*%h product=%h done=%b required %h", s8, a8[7:0], b8[7:0], r8, g8, e8[15:0]);
         end
         tests++;
         if (!g16 || r16 !== e16) begin
            fails++;
            $display("FAIL rand_w16: s=%b %h*%h product=%h done=%b required %h", s16, a16, b16, r16, g16, e16);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_corners();
      test_back_to_back();
      test_ignore_start();
      test_reset_mid_op();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
